// File: rtl/chunk_processor_stream.sv
// rtl/chunk_processor_stream.sv - registered chunk interpolator/upscaler with serialised output
//
// Accepts a (last, current) chunk pair per handshake, builds an interpolated
// chunk (AVG / HOLD / BYPASS), upscales both chunks horizontally by SCALE and
// emits them as one or two beats: interpolated chunk first, then current chunk.
//
// Ports:
//   clk, resetn        clock, synchronous active-low reset
//   in_last, in_cur    previous-frame and current-frame chunks (pixel i at [i*PW +: PW])
//   in_mode            00 AVG, 01 HOLD, 10 BYPASS, 11 AVG
//   in_sof             start-of-frame tag for the pair
//   in_valid/in_ready  input pair handshake
//   out_data           upscaled chunk (CHUNK_PIX*SCALE pixels)
//   out_is_interp      beat carries the interpolated chunk
//   out_sof/out_last   first beat of an sof pair / final beat of a pair
//   out_valid/out_ready output beat handshake
module chunk_processor_stream #(
  parameter int COMP_W    = 8,
  parameter int CHANNELS  = 3,
  parameter int CHUNK_PIX = 4,
  parameter int SCALE     = 2
) (
  input  logic                               clk,
  input  logic                               resetn,
  input  logic [CHUNK_PIX*COMP_W*CHANNELS-1:0]       in_last,
  input  logic [CHUNK_PIX*COMP_W*CHANNELS-1:0]       in_cur,
  input  logic [1:0]                         in_mode,
  input  logic                               in_sof,
  input  logic                               in_valid,
  output logic                               in_ready,
  output logic [CHUNK_PIX*SCALE*COMP_W*CHANNELS-1:0] out_data,
  output logic                               out_is_interp,
  output logic                               out_sof,
  output logic                               out_last,
  output logic                               out_valid,
  input  logic                               out_ready
);

  localparam int PW = COMP_W * CHANNELS;
  localparam int IW = CHUNK_PIX * PW;
  localparam int OW = IW * SCALE;

  typedef enum logic [1:0] {IDLE, INTERP, CUR} state_t;

  state_t        state, state_n;
  logic [IW-1:0] cur_q, interp_q, interp_c;
  logic          sof_q, bypass_q;
  logic          in_bypass, in_hold, accept;

  assign in_bypass = (in_mode == 2'b10);
  assign in_hold   = (in_mode == 2'b01);

  // out_ready feeds in_ready directly so a new pair can be taken while the
  // final beat of the previous pair leaves, giving back-to-back beats.
  assign in_ready = resetn & ((state == IDLE) | ((state == CUR) & out_ready));
  assign accept   = in_valid & in_ready;

  // (a + b + 1) >> 1 without a carry bit: halve each operand, then add the
  // round-up term, which is 1 whenever either low bit is set.
  function automatic logic [COMP_W-1:0] avg_comp(input logic [COMP_W-1:0] a,
                                                 input logic [COMP_W-1:0] b);
    avg_comp = (a >> 1) + (b >> 1) + COMP_W'(a[0] | b[0]);
  endfunction

  // Nearest-neighbour horizontal duplication: output pixel j = source pixel j/SCALE.
  function automatic logic [OW-1:0] upscale(input logic [IW-1:0] src);
    for (int j = 0; j < CHUNK_PIX * SCALE; j++) begin
      upscale[j*PW +: PW] = src[(j / SCALE) * PW +: PW];
    end
  endfunction

  always_comb begin
    interp_c = in_last;
    if (!in_hold) begin
      for (int k = 0; k < CHUNK_PIX * CHANNELS; k++) begin
        interp_c[k*COMP_W +: COMP_W] = avg_comp(in_last[k*COMP_W +: COMP_W],
                                                in_cur[k*COMP_W +: COMP_W]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state    <= IDLE;
      cur_q    <= '0;
      interp_q <= '0;
      sof_q    <= 1'b0;
      bypass_q <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        cur_q    <= in_cur;
        interp_q <= interp_c;
        sof_q    <= in_sof;
        bypass_q <= in_bypass;
      end
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (accept) state_n = in_bypass ? CUR : INTERP;
      end
      INTERP: begin
        if (out_ready) state_n = CUR;
      end
      CUR: begin
        if (out_ready) begin
          if (accept) state_n = in_bypass ? CUR : INTERP;
          else        state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    out_valid     = 1'b0;
    out_is_interp = 1'b0;
    out_sof       = 1'b0;
    out_last      = 1'b0;
    out_data      = '0;
    case (state)
      INTERP: begin
        out_valid     = 1'b1;
        out_is_interp = 1'b1;
        out_sof       = sof_q;
        out_data      = upscale(interp_q);
      end
      CUR: begin
        out_valid = 1'b1;
        out_last  = 1'b1;
        // In BYPASS the current chunk is the first beat, so it carries sof.
        out_sof   = sof_q & bypass_q;
        out_data  = upscale(cur_q);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_chunk_processor_stream.sv
// tb/tb_chunk_processor_stream.sv - scoreboard bench for chunk_processor_stream
module tb_chunk_processor_stream;

  localparam int COMP_W    = 8;
  localparam int CHANNELS  = 3;
  localparam int CHUNK_PIX = 4;
  localparam int SCALE     = 2;
  localparam int PW = COMP_W * CHANNELS;
  localparam int IW = CHUNK_PIX * PW;
  localparam int OW = IW * SCALE;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic [IW-1:0] in_last = '0, in_cur = '0;
  logic [1:0]    in_mode = 2'b00;
  logic          in_sof = 1'b0, in_valid = 1'b0;
  logic          in_ready;
  logic [OW-1:0] out_data;
  logic          out_is_interp, out_sof, out_last, out_valid;
  logic          out_ready = 1'b0;

  chunk_processor_stream #(
    .COMP_W(COMP_W), .CHANNELS(CHANNELS), .CHUNK_PIX(CHUNK_PIX), .SCALE(SCALE)
  ) dut (
    .clk(clk), .resetn(resetn),
    .in_last(in_last), .in_cur(in_cur), .in_mode(in_mode), .in_sof(in_sof),
    .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_is_interp(out_is_interp), .out_sof(out_sof),
    .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [OW-1:0] data;
    bit            interp;
    bit            sof;
    bit            last;
  } beat_t;

  beat_t sbq[$];
  int total = 0, passed = 0, beats = 0;
  bit rdy_rand = 0, rdy_fix = 0, chk_byp = 0;

  task automatic check(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    total++;
    $display("FAIL %s: bound expired", name);
  endtask

  // Reference: chunk as an array of component values, widened by repetition.
  function automatic logic [OW-1:0] model_up(input logic [IW-1:0] src);
    logic [PW-1:0] pix[$];
    logic [OW-1:0] r;
    for (int i = 0; i < CHUNK_PIX; i++)
      repeat (SCALE) pix.push_back(src[i*PW +: PW]);
    r = '0;
    foreach (pix[n]) r[n*PW +: PW] = pix[n];
    return r;
  endfunction

  function automatic logic [IW-1:0] model_avg(input logic [IW-1:0] l, input logic [IW-1:0] c);
    logic [IW-1:0] r;
    int s;
    for (int k = 0; k < CHUNK_PIX * CHANNELS; k++) begin
      s = (int'(l[k*COMP_W +: COMP_W]) + int'(c[k*COMP_W +: COMP_W]) + 1) / 2;
      r[k*COMP_W +: COMP_W] = s[COMP_W-1:0];
    end
    return r;
  endfunction

  function automatic void push_expected(input logic [IW-1:0] l, input logic [IW-1:0] c,
                                        input logic [1:0] m, input bit s);
    if (m == 2'b10) begin
      sbq.push_back('{model_up(c), 1'b0, s, 1'b1});
    end else begin
      sbq.push_back('{(m == 2'b01) ? model_up(l) : model_up(model_avg(l, c)), 1'b1, s, 1'b0});
      sbq.push_back('{model_up(c), 1'b0, 1'b0, 1'b1});
    end
  endfunction

  function automatic logic [IW-1:0] rand_chunk();
    logic [IW-1:0] v;
    for (int i = 0; i < IW; i++) v[i] = 1'($urandom_range(1));
    return v;
  endfunction

  // out_ready changes 2 time units after the edge, after the stimulus updates.
  initial forever begin
    @(posedge clk);
    #2;
    out_ready = rdy_rand ? ($urandom_range(3) != 0) : rdy_fix;
  end

  // Monitor: pops the scoreboard on each handshake, checks stall stability.
  initial begin
    bit stalled = 0;
    beat_t held;
    forever begin
      @(negedge clk);
      if (!resetn) stalled = 0;
      else begin
        if (stalled) begin
          check("hold_valid", out_valid, 1);
          check("hold_data", out_data, held.data);
          check("hold_tags", {out_is_interp, out_sof, out_last}, {held.interp, held.sof, held.last});
        end
        if (out_valid && out_ready) begin
          beats++;
          stalled = 0;
          if (sbq.size() == 0) fail_now("unexpected_beat");
          else begin
            beat_t e;
            e = sbq.pop_front();
            check("beat_data", out_data, e.data);
            check("beat_is_interp", out_is_interp, e.interp);
            check("beat_sof", out_sof, e.sof);
            check("beat_last", out_last, e.last);
          end
        end else if (out_valid) begin
          stalled = 1;
          held = '{out_data, out_is_interp, out_sof, out_last};
        end else stalled = 0;
      end
    end
  end

  task automatic send(input logic [IW-1:0] l, input logic [IW-1:0] c,
                      input logic [1:0] m, input bit s);
    bit acc = 0;
    in_last = l; in_cur = c; in_mode = m; in_sof = s; in_valid = 1'b1;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      acc = in_ready;
      if (chk_byp) check("bypass_in_ready", in_ready, 1);
      @(posedge clk);
      #1;
      if (acc) break;
    end
    if (acc) push_expected(l, c, m, s);
    else fail_now("send_timeout");
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (sbq.size() != 0 && t < 400) begin
      @(posedge clk);
      t++;
    end
    if (sbq.size() != 0) fail_now("drain_timeout");
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [IW-1:0] l, c, d0;
    int b0;
    #200000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [IW-1:0] l, c;
    logic [OW-1:0] d0;
    int b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_out_valid", out_valid, 0);
    check("reset_in_ready", in_ready, 0);
    check("reset_out_data", out_data, 0);
    check("reset_tags", {out_is_interp, out_sof, out_last}, 0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    rdy_fix = 1'b1;

    // AVG rounding vector on pixel 0
    l = rand_chunk(); c = rand_chunk();
    l[0 +: PW] = 24'h102030; c[0 +: PW] = 24'h112131;
    send(l, c, 2'b00, 1'b0);
    // AVG saturation edges, and mode 11 treated as AVG
    send({IW{1'b1}}, {IW{1'b1}}, 2'b00, 1'b0);
    send('0, {CHUNK_PIX*CHANNELS{8'h01}}, 2'b11, 1'b0);
    // HOLD with sof
    send(rand_chunk(), rand_chunk(), 2'b01, 1'b1);
    drain();

    // BYPASS burst: one pair per cycle, in_ready never drops
    chk_byp = 1;
    for (int i = 0; i < 4; i++) send(rand_chunk(), rand_chunk(), 2'b10, i == 0);
    chk_byp = 0;
    drain();

    // Backpressure on the INTERP beat
    b0 = beats;
    send(rand_chunk(), rand_chunk(), 2'b00, 1'b1);
    rdy_fix = 1'b0;
    @(negedge clk);
    d0 = out_data;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      check("stall_valid", out_valid, 1);
      check("stall_is_interp", out_is_interp, 1);
      check("stall_in_ready", in_ready, 0);
      check("stall_data", out_data, d0);
    end
    @(posedge clk);
    #1;
    rdy_fix = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("stall_beat_count", beats - b0, 2);
    check("stall_queue_empty", sbq.size(), 0);

    // Reset while the CUR beat is pending
    rdy_fix = 1'b0;
    send(rand_chunk(), rand_chunk(), 2'b10, 1'b0);
    resetn = 1'b0;
    @(posedge clk);
    sbq.delete();
    @(negedge clk);
    check("midreset_out_valid", out_valid, 0);
    check("midreset_in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    rdy_fix = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("postreset_out_valid", out_valid, 0);
      check("postreset_in_ready", in_ready, 1);
    end
    @(posedge clk);
    #1;

    // Randomised traffic with random backpressure and gaps
    rdy_rand = 1;
    for (int i = 0; i < 300; i++) begin
      repeat ($urandom_range(2)) @(posedge clk);
      #0;
      send(rand_chunk(), rand_chunk(), 2'($urandom_range(3)), 1'($urandom_range(1)));
    end
    drain();
    check("final_queue_empty", sbq.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/chunk_processor_stream.md
Name: chunk_processor_stream

Overview:
- Streaming, registered successor to the combinational chunk processor.
- Accepts a (last, current) chunk pair per input handshake and builds a temporally interpolated chunk from it, using a selectable mode.
- Upscales both the interpolated and current chunks horizontally by SCALE.
- Serialises the results onto one output stream, interpolated chunk first, then current chunk.
- Sits between the frame-buffer read path and the HDMI output formatter.

Parameters:
COMP_W, 8, bits per colour component
CHANNELS, 3, colour components per pixel (PW = COMP_W*CHANNELS)
CHUNK_PIX, 4, pixels per input chunk
SCALE, 2, horizontal upscale factor (>=1); output chunk = CHUNK_PIX*SCALE pixels

Ports:
clk  in  1  clock
resetn  in  1  synchronous active-low reset
in_last  in  CHUNK_PIX*PW  co-located chunk from the previous frame
in_cur  in  CHUNK_PIX*PW  chunk from the current frame
in_mode  in  2  00 AVG, 01 HOLD, 10 BYPASS, 11 treated as AVG
in_sof  in  1  start-of-frame tag for this pair
in_valid  in  1  input pair valid
in_ready  out  1  block can accept a pair
out_data  out  CHUNK_PIX*SCALE*PW  upscaled chunk
out_is_interp  out  1  1 = beat carries the interpolated chunk
out_sof  out  1  first beat of a pair whose in_sof was 1
out_last  out  1  final beat of the current pair
out_valid  out  1  output beat valid
out_ready  in  1  downstream accepts the beat

Behaviour:
- One clock domain; all state changes on rising clk.
- Reset: with resetn=0 at an edge, the following take effect that cycle:
  - out_valid, out_is_interp, out_sof, out_last = 0; out_data = 0.
  - State = IDLE; any held pair is discarded.
- in_ready is 0 while resetn=0.
- Pixel packing: pixel i at bits [i*PW +: PW]; component c of a pixel at [c*COMP_W +: COMP_W].
- Upscale: output pixel j = source pixel floor(j/SCALE) (nearest-neighbour duplication). SCALE=1 is a pass-through.
- Interpolated chunk, computed per component:
  - AVG: (last + cur + 1) >> 1. Compute in COMP_W+1 bits, round half up, result never overflows COMP_W.
  - HOLD: equals last.
  - BYPASS: no interpolated beat is emitted.
- Capture: on in_valid & in_ready, register in_cur, in_sof and the decoded mode, plus the interpolated result computed combinationally from the inputs. Mode is sampled only at acceptance.
- State machine:
  - IDLE: out_valid=0. On accept, go to INTERP (AVG/HOLD) or CUR (BYPASS).
  - INTERP: out_valid=1, out_is_interp=1, out_last=0, out_sof=captured sof, out_data = upscaled interpolated chunk. On out_ready, go to CUR.
  - CUR: out_valid=1, out_is_interp=0, out_last=1, out_data = upscaled current chunk. out_sof = captured sof only in BYPASS, else 0. On out_ready, go IDLE; if a new pair is accepted in the same cycle, go directly to INTERP/CUR for that pair.
- in_ready = (state==IDLE) | (state==CUR & out_ready). This is a combinational path from out_ready, by design.
- Latency: a pair accepted at edge N presents its first beat from cycle N+1.
- Throughput, with out_ready held high and no bubbles:
  - AVG/HOLD: 1 pair per 2 cycles.
  - BYPASS: 1 pair per cycle.
- Backpressure: while out_valid=1 and out_ready=0, out_data and all tags hold stable. No beat is dropped or duplicated.
- in_valid=1 while in_ready=0: no capture; upstream must hold the pair stable.
- Reset asserted mid-pair: the remaining beats are not emitted. After release, the first beat belongs to the next accepted pair.

Test Plan:
- AVG, COMP_W=8, last pixel0 = 0x10_20_30, cur pixel0 = 0x11_21_31, out_ready=1 -> beat1 is_interp=1, pixel0 = pixel1 = 0x11_21_31 (round up). Beat2 is_interp=0, last=1, pixel0 = pixel1 = 0x11_21_31.
- AVG, all components last=0xFF, cur=0xFF -> interp components 0xFF (no overflow). last=0x00, cur=0x01 -> 0x01.
- HOLD, in_sof=1 -> beat1 equals upscaled in_last with out_sof=1. Beat2 has out_sof=0 and out_last=1.
- BYPASS stream of 4 pairs, out_ready=1 -> 4 consecutive single beats, each is_interp=0, last=1, in_ready constant 1.
- AVG, out_ready low for 3 cycles during the INTERP beat -> out_data stable and in_ready=0 throughout. Release yields exactly 2 beats.
- Assert resetn=0 while in the CUR state -> next cycle out_valid=0, in_ready=0. After release, in_ready=1 and no stale beat appears.
